// File: rtl/root_job_dispatcher.sv
// Front end for the k-th root core: queues requests, runs one job at a time,
// holds operands stable, and returns tagged results with timeout protection.
module root_job_dispatcher #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [9:0]       req_radicand,
  input  logic [2:0]       req_degree,
  input  logic [TAG_W-1:0] req_tag,
  output logic             core_in_valid,
  output logic [9:0]       core_in_data_1,
  output logic [2:0]       core_in_data_2,
  input  logic             core_out_valid,
  input  logic [19:0]      core_out_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [19:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err,
  output logic             core_fault
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 13 + TAG_W;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StLaunch, StWait, StResult, StGap} state_e;

  state_e           state;
  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;
  logic [EW-1:0]    head;
  logic [9:0]       head_rad;
  logic [2:0]       head_deg;
  logic [TAG_W-1:0] head_tag;
  logic [9:0]       op_rad;
  logic [2:0]       op_deg;
  logic [TAG_W-1:0] op_tag;
  logic [TW-1:0]    timer;
  logic             cov_q;
  logic             cov_rise;

  assign req_ready = (count < CW'(DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = (state == StIdle) && (count != '0);
  assign head      = mem[rd_ptr];
  assign head_tag  = head[TAG_W-1:0];
  assign head_deg  = head[TAG_W +: 3];
  assign head_rad  = head[TAG_W+3 +: 10];
  assign cov_rise  = core_out_valid && !cov_q;

  // The core reads the degree combinationally each iteration, so operands stay put until WAIT ends.
  assign core_in_data_1 = (state == StLaunch || state == StWait) ? op_rad : '0;
  assign core_in_data_2 = (state == StLaunch || state == StWait) ? op_deg : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req_radicand, req_degree, req_tag};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= StIdle;
      core_in_valid <= 1'b0;
      res_valid     <= 1'b0;
      res_data      <= '0;
      res_tag       <= '0;
      res_err       <= 1'b0;
      core_fault    <= 1'b0;
      op_rad        <= '0;
      op_deg        <= '0;
      op_tag        <= '0;
      timer         <= '0;
      cov_q         <= 1'b0;
    end else begin
      cov_q <= core_out_valid;
      case (state)
        StIdle: begin
          if (pop) begin
            op_rad <= head_rad;
            op_deg <= head_deg;
            op_tag <= head_tag;
            if (head_deg != 3'd0 && head_deg <= 3'd5 && !core_fault) begin
              core_in_valid <= 1'b1;
              state         <= StLaunch;
            end else begin
              res_valid <= 1'b1;
              res_data  <= '0;
              res_err   <= 1'b1;
              res_tag   <= head_tag;
              state     <= StResult;
            end
          end
        end
        StLaunch: begin
          core_in_valid <= 1'b0;
          timer         <= '0;
          state         <= StWait;
        end
        StWait: begin
          timer <= timer + TW'(1);
          // Only a fresh rising edge counts; a level left high never re-captures.
          if (cov_rise) begin
            res_valid <= 1'b1;
            res_data  <= core_out_data;
            res_err   <= 1'b0;
            res_tag   <= op_tag;
            state     <= StResult;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            res_valid  <= 1'b1;
            res_data   <= '0;
            res_err    <= 1'b1;
            res_tag    <= op_tag;
            core_fault <= 1'b1;
            state      <= StResult;
          end
        end
        StResult: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= StGap;
          end
        end
        StGap: begin
          if (!core_out_valid) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
